// File: rtl/write_fsm_top.sv
`default_nettype none
// ============================================================================
// Module   : write_fsm_top
// Purpose  : Write-side sequencer. On start it accepts a programmed number
//            of valid/ready data beats and issues one registered memory
//            write per beat at base address + beat index (wrapping).
//            Optional feature macro: WRITE_FSM_ABORT_EN (adds abort_i).
// Revision : 1.0 - initial release
// ============================================================================
module write_fsm_top #(
  parameter int CNT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  cnt_val_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
`ifdef WRITE_FSM_ABORT_EN
  input  logic                  abort_i,
`endif
  input  logic                  wdata_valid_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  wdata_ready_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  output logic                  idle_o,
  output logic                  run_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  w_abort;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_last_beat;
  logic                  w_start;

`ifdef WRITE_FSM_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  // Abort gates ready combinationally so no beat slips in on the abort cycle.
  assign w_ready     = (r_state == S_RUN) && !w_abort;
  assign w_accept    = w_ready && wdata_valid_i;
  assign w_last_beat = (r_cnt == (r_len - CNT_WIDTH'(1)));
  assign w_start     = (r_state == S_IDLE) && start_i;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next_state = (cnt_val_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_abort || (w_accept && w_last_beat)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Transaction parameters, beat counter and registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_len     <= '0;
      r_base    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_start) begin
        r_len  <= cnt_val_i;
        r_base <= base_addr_i;
        r_cnt  <= '0;
      end
      if (w_accept) begin
        r_cnt     <= r_cnt + CNT_WIDTH'(1);
        r_wr_en   <= 1'b1;
        // Truncation to ADDR_WIDTH gives the intended silent wrap.
        r_wr_addr <= r_base + ADDR_WIDTH'(r_cnt);
        r_wr_data <= wdata_i;
      end
    end
  end

  assign wdata_ready_o = w_ready;
  assign wr_en_o       = r_wr_en;
  assign wr_addr_o     = r_wr_addr;
  assign wr_data_o     = r_wr_data;
  assign cnt_o         = r_cnt;
  assign idle_o        = (r_state == S_IDLE);
  assign run_o         = (r_state == S_RUN);
  assign done_o        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_write_fsm_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_fsm_top
// Purpose  : Self-checking bench for write_fsm_top. Expected writes are
//            queued as beats are driven and popped when wr_en_o fires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_write_fsm_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [7:0]  cnt_val_i;
  logic [7:0]  base_addr_i;
  logic        abort_i;
  logic        wdata_valid_i;
  logic [31:0] wdata_i;
  logic        wdata_ready_o;
  logic        wr_en_o;
  logic [7:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic [7:0]  cnt_o;
  logic        idle_o;
  logic        run_o;
  logic        done_o;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc      = 0;

  write_fsm_top #(.CNT_WIDTH(8), .ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .cnt_val_i    (cnt_val_i),
    .base_addr_i  (base_addr_i),
`ifdef WRITE_FSM_ABORT_EN
    .abort_i      (abort_i),
`endif
    .wdata_valid_i(wdata_valid_i),
    .wdata_i      (wdata_i),
    .wdata_ready_o(wdata_ready_o),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .cnt_o        (cnt_o),
    .idle_o       (idle_o),
    .run_o        (run_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (wr_en_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_wr", 64'(wr_addr_o), 64'hDEAD);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_cycle", 64'(cyc), 64'(e.cyc));
        check("wr_addr", 64'(wr_addr_o), 64'(e.addr));
        check("wr_data", 64'(wr_data_o), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction from IDLE. pattern bit i is valid in RUN cycle i+1
  // (beyond 32 cycles valid is held high). abort_at > 0 raises abort in that
  // RUN cycle. Returns after the idle check.
  task automatic drive_txn(input int len, input logic [7:0] base, input logic [31:0] pattern,
                           input logic [31:0] dbase, input int abort_at);
    int  acc = 0;
    int  i   = 0;
    bit  v;
    bit  aborted = 0;
    start_i = 1'b1; cnt_val_i = 8'(len); base_addr_i = base; wdata_valid_i = 1'b0;
    tick();
    start_i = 1'b0;
    check("run_after_start", 64'(run_o), 64'(len != 0));
    while (acc < len && !aborted && i < 200) begin
      v = (i < 32) ? pattern[i] : 1'b1;
      wdata_valid_i = v;
      wdata_i = dbase + 32'(acc);
      abort_i = (abort_at == i + 1);
      if (abort_i) begin
        check("ready_abort", 64'(wdata_ready_o), 64'd0);
        aborted = 1;
      end else begin
        check("ready_run", 64'(wdata_ready_o), 64'd1);
        if (v) begin
          sb.push_back('{cyc: cyc + 1, addr: base + 8'(acc), data: dbase + 32'(acc)});
          acc++;
        end
      end
      tick();
      i++;
    end
    wdata_valid_i = 1'b0;
    abort_i = 1'b0;
    check("done_flag", 64'(done_o), 64'd1);
    check("ready_done", 64'(wdata_ready_o), 64'd0);
    check("cnt_final", 64'(cnt_o), 64'(acc));
    tick();
    check("idle_after", 64'(idle_o), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0; cnt_val_i = '0; base_addr_i = '0;
    abort_i = 1'b0; wdata_valid_i = 1'b0; wdata_i = '0;
    tick(); tick();
    // Reset state
    check("rst_idle", 64'(idle_o), 64'd1);
    check("rst_run", 64'(run_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_ready", 64'(wdata_ready_o), 64'd0);
    check("rst_wr_en", 64'(wr_en_o), 64'd0);
    check("rst_wr_addr", 64'(wr_addr_o), 64'd0);
    check("rst_wr_data", 64'(wr_data_o), 64'd0);
    check("rst_cnt", 64'(cnt_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic transaction
    drive_txn(4, 8'h10, 32'hFFFF_FFFF, 32'hA0, 0);
    // Backpressure: valid 1,0,0,1,0,1
    drive_txn(3, 8'h20, 32'b101001, 32'h100, 0);
    // Address wrap
    drive_txn(4, 8'hFE, 32'hFFFF_FFFF, 32'h5500, 0);

    // Zero length, second start pulsed during done
    start_i = 1'b1; cnt_val_i = 8'd0; base_addr_i = 8'h30;
    tick();
    check("zl_done", 64'(done_o), 64'd1);
    check("zl_cnt", 64'(cnt_o), 64'd0);
    cnt_val_i = 8'd5; wdata_valid_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("zl_idle", 64'(idle_o), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("zl_idle_stable", 64'(idle_o), 64'd1);
      check("zl_ready_low", 64'(wdata_ready_o), 64'd0);
    end
    wdata_valid_i = 1'b0;

    // Reset mid-transaction after 2 of 5 beats
    start_i = 1'b1; cnt_val_i = 8'd5; base_addr_i = 8'h40; wdata_valid_i = 1'b0;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wdata_valid_i = 1'b1; wdata_i = 32'hB0 + 32'(k);
      sb.push_back('{cyc: cyc + 1, addr: 8'h40 + 8'(k), data: 32'hB0 + 32'(k)});
      tick();
    end
    wdata_i = 32'hBEEF;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_idle", 64'(idle_o), 64'd1);
    check("mid_rst_cnt", 64'(cnt_o), 64'd0);
    check("mid_rst_wr_en", 64'(wr_en_o), 64'd0);
    check("mid_rst_wr_addr", 64'(wr_addr_o), 64'd0);
    for (int k = 0; k < 4; k++) tick();
    check("mid_rst_still_idle", 64'(idle_o), 64'd1);
    check("mid_rst_sb", 64'(sb.size()), 64'd0);
    wdata_valid_i = 1'b0;
    tick();

`ifdef WRITE_FSM_ABORT_EN
    // Abort on the 4th valid beat of an 8-beat transaction
    drive_txn(8, 8'h60, 32'hFFFF_FFFF, 32'hC0, 4);
`endif

    // Back-to-back transaction after the others still behaves
    drive_txn(2, 8'h80, 32'hFFFF_FFFF, 32'hD0, 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
